// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies finish in one cycle
// through a full-width product; divides are unaffected.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned    CW  = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Operand conditioning at request time
   logic            a_sgn, b_sgn, a_neg, b_neg, res_neg, div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag;

   assign a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3[2] && !funct3[0]);
   assign b_sgn    = (funct3 == 3'd1) || (funct3[2] && !funct3[0]);
   assign a_neg    = a_sgn & op_a[XLEN-1];
   assign b_neg    = b_sgn & op_b[XLEN-1];
   assign a_mag    = a_neg ? -op_a : op_a;
   assign b_mag    = b_neg ? -op_b : op_b;
   // Remainder takes the dividend sign; everything else the product/quotient sign
   assign res_neg  = (funct3 == 3'd6) ? a_neg : (a_neg ^ b_neg);
   assign div_zero = funct3[2] && (op_b == '0);
   assign div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN) && (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

   // One iteration step. Multiply: acc = {partial product, remaining multiplier}.
   // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
   logic              rem_ge;
   logic [2*XLEN-1:0] mul_step, div_step, acc_step;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
   assign mul_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, opb_q};
   // Shifted remainder is below twice the divisor, so the top bit is a clean borrow
   assign rem_ge   = ~rem_diff[XLEN];
   assign div_step = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
   assign acc_step = f3_q[2] ? div_step : mul_step;

   // Sign fix and output selection from a {hi, lo} magnitude pair
   function automatic logic [XLEN-1:0] finalize(input logic [2:0] f3, input logic neg,
                                                input logic [2*XLEN-1:0] val);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   q, r, res;
      p = neg ? -val : val;
      q = neg ? -val[XLEN-1:0] : val[XLEN-1:0];
      r = neg ? -val[2*XLEN-1:XLEN] : val[2*XLEN-1:XLEN];
      case (f3)
         3'd0:                res = p[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    res = p[2*XLEN-1:XLEN];
         3'd4, 3'd5:          res = q;
         default:             res = r;
      endcase
      return res;
   endfunction

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               f3_d    = funct3;
               neg_d   = res_neg;
               opb_d   = b_mag;
               acc_d   = {{XLEN{1'b0}}, a_mag};
               cnt_d   = CW'(XLEN - 1);
               state_d = S_CALC;
               if (div_zero) begin
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : MIN;
                  state_d  = S_DONE;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!funct3[2]) begin
                  result_d = finalize(funct3, res_neg, fast_prod);
                  state_d  = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            // Last step is folded into the finishing cycle
            if (cnt_q == '0) begin
               result_d = finalize(f3_q, neg_q, acc_step);
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the ALU, directly downstream of the register file. It takes the two register-file read operands (rs1/rs2 values) plus funct3. It produces a 32-bit result that the writeback mux returns to the register file. A multi-cycle handshake lets the control unit stall the PC and hold RegWrite until the result is ready.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  XLEN  rs1 value (register-file dataA).
- op_b  in  XLEN  rs2 value (register-file dataB).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  final value; held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterative computation.
  - DONE: result available; done pulses.
- IDLE & start:
  - Latch funct3 and operands.
  - Convert signed operands to magnitudes and record the result sign:
    - MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - DIV/REM: both operands signed.
  - Load the step counter with XLEN-1 and go to CALC.
  - Special cases go straight to DONE instead (result below).
- Start while busy is ignored; no queueing.
- Multiply: radix-2 shift-add into a 2*XLEN accumulator, one multiplier bit per cycle.
- Divide: restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- CALC with counter==0:
  - Apply the sign fix (two's-complement negate when the recorded sign is set).
  - Select the output:
    - MUL: low half of the product.
    - MULH*: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into result and go to DONE.
- Remainder sign follows the dividend; quotient sign is sign(a) XOR sign(b).
- Special cases (1-cycle, no iteration):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start in that DONE cycle is ignored.
- Reset (any time, including mid-CALC):
  - Outputs: state=IDLE, busy=0, done=0, result=0.
  - Internal: accumulator and counter cleared.

## Timing
- Start accepted at edge 0.
- Normal op: CALC occupies XLEN cycles; done is high in the cycle after edge XLEN+1. Latency is XLEN+1 cycles (33 at default).
- Special case: done in the cycle after edge 1 (latency 1).
- busy rises the cycle after the accepting edge and falls together with done.
- Stall rule for the core: stall = (start & ~busy) | (busy & ~done). The register file writes result on the done cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - All four multiply ops use a single-cycle XLEN×XLEN product, registered at the accepting edge.
  - FSM goes IDLE→DONE; latency 1.
  - Divide ops are unchanged.
- Undefined: multiplies use the iterative path, latency XLEN+1. There is no hardware multiplier.

## Test plan
- MUL 7×6 → done once at latency 33 (1 with MULDIV_FAST_MUL_EN), result=42; busy high exactly 33 cycles.
- MULH 0xFFFFFFFF(−1)×0xFFFFFFFF(−1) → 0x00000000; MULHU with the same operands → 0xFFFFFFFE; MULHSU (−1, 2) → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both at latency 1. DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Second start asserted on every cycle while busy → ignored. Exactly one done per accepted start, and the first result is unchanged until the next request.
- rst pulsed at CALC cycle 10 → busy=0, done=0, result=0 immediately. A new start after release completes normally with the correct value.
